// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the writeback/commit slice: datapath width,
// load funct3 encodings and the hard-wired zero register.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_return_fifo.sv
// Small power-of-two FIFO holding extracted load results ({rd, data}) until
// the commit stage has a free slot.
module load_return_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when the head pops in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which entries are valid, so clearing them is enough.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: merges ALU results with queued load returns into a
// registered register-file write port, with load scoreboard and forwarding.
module wb_commit_unit
  import rv32_pkg::*;
#(
  parameter int XLEN     = rv32_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic            iss_ld_valid,
  input  logic [4:0]      iss_ld_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hazard_stall,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] data_des,
  output logic            data_valid
);

  localparam int ENTRY_W = 5 + XLEN;
  localparam int CNT_W   = $clog2(LQ_DEPTH) + 1;

  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    ld_ext;
  logic               lq_push, lq_pop, lq_full, lq_empty;
  logic [ENTRY_W-1:0] lq_head;
  logic [CNT_W-1:0]   lq_count;
  logic [4:0]         head_rd;
  logic [XLEN-1:0]    head_data;

  logic [4:0]         rd_q, rd_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               valid_q, valid_d;
  logic [31:0]        pend_q, pend_d;

  // Extraction happens before the FIFO so the queue holds final values.
  // NOTE: every always_comb output gets a value on every path (defaults or a
  // case default) so no latch is inferred.
  always_comb begin
    ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_LB:   ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = ld_word;
    endcase
  end

  assign ld_ready = rst && !lq_full;
  assign lq_push  = ld_valid && ld_ready;
  assign lq_pop   = !alu_valid && !lq_empty;

  load_return_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_lq (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (lq_push),
    .din_i   ({ld_rd, ld_ext}),
    .pop_i   (lq_pop),
    .dout_o  (lq_head),
    .full_o  (lq_full),
    .empty_o (lq_empty),
    .count_o (lq_count)
  );

  assign head_rd   = lq_head[ENTRY_W-1 -: 5];
  assign head_data = lq_head[XLEN-1:0];

  // ALU has absolute priority; it cannot be back-pressured.
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = 1'b0;
    pend_d  = pend_q;
    if (alu_valid) begin
      rd_d    = alu_rd;
      data_d  = alu_data;
      valid_d = (alu_rd != REG_X0);
    end else if (lq_pop) begin
      rd_d    = head_rd;
      data_d  = head_data;
      valid_d = (head_rd != REG_X0);
      pend_d[head_rd] = 1'b0;
    end
    if (iss_ld_valid && iss_ld_rd != REG_X0) pend_d[iss_ld_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (lq_empty == (lq_count == '0));
  end

  assign rd           = rd_q;
  assign data_des     = data_q;
  assign data_valid   = valid_q;
  assign fwd_data     = data_q;
  assign hazard_stall = pend_q[chk_rs1] | pend_q[chk_rs2] | pend_q[chk_rd];
  assign fwd_rs1_hit  = valid_q && (rd_q == chk_rs1) && (rd_q != REG_X0);
  assign fwd_rs2_hit  = valid_q && (rd_q == chk_rs2) && (rd_q != REG_X0);

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit: reset, load extraction,
// arbitration, scoreboard stall/forwarding and x0 commits.
module tb_wb_commit_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_word;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        iss_ld_valid;
  logic [4:0]  iss_ld_rd;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        hazard_stall, fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_data;
  logic [4:0]  rd;
  logic [31:0] data_des;
  logic        data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]  ext_f3   [8] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LH, 3'b011};
  logic [1:0]  ext_lo   [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
  logic [31:0] ext_word [8] = '{32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB,
                                32'h8899AABB, 32'h12345678, 32'h8899AABB, 32'h0BADF00D};
  logic [31:0] ext_exp  [8] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                32'h8899AABB, 32'h00000078, 32'hFFFFAABB, 32'h0BADF00D};

  wb_commit_unit #(.XLEN(32), .LQ_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_word      (ld_word),
    .ld_funct3    (ld_funct3),
    .ld_addr_lo   (ld_addr_lo),
    .iss_ld_valid (iss_ld_valid),
    .iss_ld_rd    (iss_ld_rd),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .chk_rd       (chk_rd),
    .hazard_stall (hazard_stall),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_data     (fwd_data),
    .rd           (rd),
    .data_des     (data_des),
    .data_valid   (data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_word = 0; ld_funct3 = 0; ld_addr_lo = 0;
    iss_ld_valid = 0; iss_ld_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic drive_load(input logic [4:0] r, input logic [31:0] w,
                            input logic [2:0] f3, input logic [1:0] lo);
    ld_valid = 1; ld_rd = r; ld_word = w; ld_funct3 = f3; ld_addr_lo = lo;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1111_2222;
    drive_load(5'd4, 32'hDEAD_BEEF, F3_LW, 2'd0);
    iss_ld_valid = 1; iss_ld_rd = 5'd5; chk_rs1 = 5'd5;
    repeat (3) tick();
    n_tests++; if ({data_valid, rd, data_des} !== {1'b0, 5'd0, 32'd0}) begin n_fail++;
      $display("FAIL reset_outputs: got v=%b rd=%0d d=%h want v=0 rd=0 d=0", data_valid, rd, data_des); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", hazard_stall); end
    idle();
    rst = 1;
    #1;
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", ld_ready); end
    tick();
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_write: got %b want 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    idle();
    drive_load(5'd10, 32'hA5A5_5A5A, F3_LW, 2'd0);
    tick();
    ld_valid = 0;
    rst = 0;
    tick();
    rst = 1;
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_edge: got v=%b want 0", data_valid); end
    tick();
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_dropped: got v=%b rd=%0d want v=0", data_valid, rd); end
  endtask

  task automatic test_extract();
    idle();
    for (int i = 0; i < 8; i++) begin
      drive_load(5'(10 + i), ext_word[i], ext_f3[i], ext_lo[i]);
      tick();
      ld_valid = 0;
      tick();
      n_tests++;
      if ({data_valid, rd, data_des} !== {1'b1, 5'(10 + i), ext_exp[i]}) begin n_fail++;
        $display("FAIL extract_%0d: got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                 i, data_valid, rd, data_des, 10 + i, ext_exp[i]); end
    end
    tick();
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL extract_idle: got v=%b want 0", data_valid); end
  endtask

  task automatic test_arbitration();
    idle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0303;
    drive_load(5'd7, 32'h7777_0007, F3_LW, 2'd0);
    tick();
    n_tests++; if ({data_valid, rd, data_des, ld_ready} !== {1'b1, 5'd3, 32'h0000_0303, 1'b1}) begin n_fail++;
      $display("FAIL arb_alu3: got v=%b rd=%0d d=%h rdy=%b want 1/3/00000303/1", data_valid, rd, data_des, ld_ready); end
    alu_rd = 5'd4; alu_data = 32'h0000_0404;
    drive_load(5'd8, 32'h8888_0008, F3_LW, 2'd0);
    tick();
    n_tests++; if ({data_valid, rd, data_des, ld_ready} !== {1'b1, 5'd4, 32'h0000_0404, 1'b0}) begin n_fail++;
      $display("FAIL arb_alu4: got v=%b rd=%0d d=%h rdy=%b want 1/4/00000404/0", data_valid, rd, data_des, ld_ready); end
    alu_rd = 5'd5; alu_data = 32'h0000_0505;
    drive_load(5'd9, 32'h9999_0009, F3_LW, 2'd0);
    tick();
    n_tests++; if ({data_valid, rd, data_des, ld_ready} !== {1'b1, 5'd5, 32'h0000_0505, 1'b0}) begin n_fail++;
      $display("FAIL arb_alu5: got v=%b rd=%0d d=%h rdy=%b want 1/5/00000505/0", data_valid, rd, data_des, ld_ready); end
    alu_rd = 5'd6; alu_data = 32'h0000_0606;
    tick();
    n_tests++; if ({data_valid, rd, data_des, ld_ready} !== {1'b1, 5'd6, 32'h0000_0606, 1'b0}) begin n_fail++;
      $display("FAIL arb_alu6: got v=%b rd=%0d d=%h rdy=%b want 1/6/00000606/0", data_valid, rd, data_des, ld_ready); end
    alu_valid = 0;
    tick();
    n_tests++; if ({data_valid, rd, data_des, ld_ready} !== {1'b1, 5'd7, 32'h7777_0007, 1'b1}) begin n_fail++;
      $display("FAIL arb_ld7: got v=%b rd=%0d d=%h rdy=%b want 1/7/77770007/1", data_valid, rd, data_des, ld_ready); end
    tick();
    ld_valid = 0;
    n_tests++; if ({data_valid, rd, data_des} !== {1'b1, 5'd8, 32'h8888_0008}) begin n_fail++;
      $display("FAIL arb_ld8: got v=%b rd=%0d d=%h want 1/8/88880008", data_valid, rd, data_des); end
    tick();
    n_tests++; if ({data_valid, rd, data_des} !== {1'b1, 5'd9, 32'h9999_0009}) begin n_fail++;
      $display("FAIL arb_ld9: got v=%b rd=%0d d=%h want 1/9/99990009", data_valid, rd, data_des); end
    tick();
    n_tests++; if ({data_valid, rd, data_des} !== {1'b0, 5'd9, 32'h9999_0009}) begin n_fail++;
      $display("FAIL arb_drain: got v=%b rd=%0d d=%h want 0/9/99990009", data_valid, rd, data_des); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_ld_valid = 1; iss_ld_rd = 5'd5;
    tick();
    iss_ld_valid = 0; chk_rs1 = 5'd5; #1;
    n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sb_rs1_stall: got %b want 1", hazard_stall); end
    chk_rs1 = 5'd1; chk_rs2 = 5'd5; #1;
    n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sb_rs2_stall: got %b want 1", hazard_stall); end
    chk_rs2 = 5'd2; chk_rd = 5'd5; #1;
    n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sb_rd_stall: got %b want 1", hazard_stall); end
    chk_rd = 5'd6; #1;
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sb_no_stall: got %b want 0", hazard_stall); end
    chk_rs1 = 5'd5; chk_rs2 = 5'd4; chk_rd = 5'd0;
    drive_load(5'd5, 32'hCAFE_F00D, F3_LW, 2'd0);
    tick();
    ld_valid = 0;
    n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_queued: got %b want 1", hazard_stall); end
    tick();
    n_tests++; if ({hazard_stall, data_valid, fwd_rs1_hit, fwd_rs2_hit, fwd_data} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D}) begin n_fail++;
      $display("FAIL sb_fwd: got stall=%b v=%b h1=%b h2=%b fd=%h want 0/1/1/0/cafef00d",
               hazard_stall, data_valid, fwd_rs1_hit, fwd_rs2_hit, fwd_data); end
    chk_rs2 = 5'd5; #1;
    n_tests++; if (fwd_rs2_hit !== 1'b1) begin n_fail++; $display("FAIL sb_fwd_rs2: got %b want 1", fwd_rs2_hit); end
    tick();
    n_tests++; if (fwd_rs1_hit !== 1'b0) begin n_fail++; $display("FAIL sb_fwd_expired: got %b want 0", fwd_rs1_hit); end
    idle();
    iss_ld_valid = 1; iss_ld_rd = 5'd0;
    tick();
    iss_ld_valid = 0; #1;
    n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sb_x0_stall: got %b want 0", hazard_stall); end
  endtask

  task automatic test_same_cycle();
    idle();
    iss_ld_valid = 1; iss_ld_rd = 5'd9;
    tick();
    iss_ld_valid = 0; chk_rs1 = 5'd9;
    drive_load(5'd9, 32'h0000_0091, F3_LW, 2'd0);
    tick();
    ld_valid = 0;
    iss_ld_valid = 1; iss_ld_rd = 5'd9;
    tick();
    iss_ld_valid = 0; #1;
    n_tests++; if ({data_valid, rd, data_des, hazard_stall} !== {1'b1, 5'd9, 32'h0000_0091, 1'b1}) begin n_fail++;
      $display("FAIL same_first: got v=%b rd=%0d d=%h stall=%b want 1/9/00000091/1", data_valid, rd, data_des, hazard_stall); end
    tick();
    n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL same_persist: got %b want 1", hazard_stall); end
    drive_load(5'd9, 32'h0000_0092, F3_LW, 2'd0);
    tick();
    ld_valid = 0;
    tick();
    n_tests++; if ({data_valid, rd, data_des, hazard_stall} !== {1'b1, 5'd9, 32'h0000_0092, 1'b0}) begin n_fail++;
      $display("FAIL same_second: got v=%b rd=%0d d=%h stall=%b want 1/9/00000092/0", data_valid, rd, data_des, hazard_stall); end
  endtask

  task automatic test_x0_commit();
    idle();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    tick();
    alu_valid = 0; chk_rs1 = 5'd0; #1;
    n_tests++; if ({data_valid, rd, data_des, fwd_rs1_hit} !== {1'b0, 5'd0, 32'h0000_1234, 1'b0}) begin n_fail++;
      $display("FAIL x0_commit: got v=%b rd=%0d d=%h h1=%b want 0/0/00001234/0", data_valid, rd, data_des, fwd_rs1_hit); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_extract();
    test_arbitration();
    test_scoreboard();
    test_same_cycle();
    test_x0_commit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
